mux2_rr_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one mux_2x1-style datapath between two requesters (A, B).

---
 rtl/mux2_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Round-robin arbiter/sequencer that shares one 2:1 mux datapath between two
// producers (A and B) feeding a single downstream consumer. The block owns
// the mux select. It registers the grants, drives sel and forwards the
// granted side's payload as a valid-qualified beat stream.
//
// Each ownership is bounded to MAX_BURST beats, but only while the other side
// is waiting. A lone requester may stream indefinitely.
//
// Parameters
//   DATA_W     payload width of data_a / data_b / out_data
//   MAX_BURST  maximum consecutive beats for one side while the other waits (>=1)
//   CNT_W      burst counter width, must be able to hold MAX_BURST
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-low
//   req_a/b    side requests / holds the datapath
//   last_a/b   side's final beat this cycle (only honoured on a granted beat)
//   data_a/b   side payloads
//   gnt_a/b    registered grants (never both high)
//   sel        registered mux select, 0 = A, 1 = B
//   out_data   sel ? data_b : data_a (combinational)
//   out_valid  granted side is requesting this cycle (a beat)
//   busy       arbiter currently has an owner
//   beats_a/b  (only with MUX2_ARB_STATS_EN) saturating 16-bit per-side beat
//              counters, cleared by rst_n
//
// Optional feature macro: MUX2_ARB_STATS_EN
// -----------------------------------------------------------------------------
module mux2_rr_arbiter #(
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              last_a,
  input  logic              last_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]       beats_a,
  output logic [15:0]       beats_b
`endif
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;     // 0 = A has priority next, 1 = B
  logic             sel_q, sel_d;

  // Owner-relative view of the inputs, so A and B share one release rule.
  logic             own_req;
  logic             other_req;
  logic             own_last;
  logic             beat;
  logic [CNT_W-1:0] cnt_inc;
  logic             limit_hit;
  logic             release_own;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst counter, round-robin pointer and mux select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rr_q  <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      sel_q <= sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner-relative decode and release condition
  // ---------------------------------------------------------------------------
  always_comb begin
    own_req   = 1'b0;
    other_req = 1'b0;
    own_last  = 1'b0;
    case (state_q)
      ST_OWN_A: begin
        own_req   = req_a;
        other_req = req_b;
        own_last  = last_a;
      end
      ST_OWN_B: begin
        own_req   = req_b;
        other_req = req_a;
        own_last  = last_b;
      end
      default: begin
        own_req   = 1'b0;
        other_req = 1'b0;
        own_last  = 1'b0;
      end
    endcase

    // own_req is forced low in IDLE, so a beat only exists with a grant.
    beat = own_req;

    // Saturating increment: a lone owner keeps streaming at MAX_BURST, so a
    // late request from the other side hands over after the current beat.
    cnt_inc = (cnt_q >= MAX_C) ? MAX_C : cnt_q + 1'b1;

    limit_hit = beat && (cnt_inc == MAX_C) && other_req;

    // last_x only counts on a beat. Once own_req is low, release is
    // unconditional, so own_last needs no further qualifying here.
    release_own = !own_req || own_last || limit_hit;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_a && req_b) begin
          state_d = rr_q ? ST_OWN_B : ST_OWN_A;
        end else if (req_a) begin
          state_d = ST_OWN_A;
        end else if (req_b) begin
          state_d = ST_OWN_B;
        end
      end

      ST_OWN_A: begin
        if (release_own) begin
          rr_d    = 1'b1;
          cnt_d   = '0;
          state_d = req_b ? ST_OWN_B : ST_IDLE;
        end else if (beat) begin
          cnt_d = cnt_inc;
        end
      end

      ST_OWN_B: begin
        if (release_own) begin
          rr_d    = 1'b0;
          cnt_d   = '0;
          state_d = req_a ? ST_OWN_A : ST_IDLE;
        end else if (beat) begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The select follows the grant onto the same edge. While IDLE it keeps the
  // last owner's select so the mux does not toggle needlessly.
  always_comb begin
    sel_d = sel_q;
    if (state_d == ST_OWN_A) begin
      sel_d = 1'b0;
    end else if (state_d == ST_OWN_B) begin
      sel_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_a     = (state_q == ST_OWN_A);
    gnt_b     = (state_q == ST_OWN_B);
    busy      = (state_q != ST_IDLE);
    sel       = sel_q;
    out_data  = sel_q ? data_b : data_a;
    out_valid = (gnt_a && req_a) || (gnt_b && req_b);
  end

`ifdef MUX2_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Per-side saturating beat counters (index 0 = A, 1 = B)
  // ---------------------------------------------------------------------------
  logic [1:0]  side_beat;
  logic [15:0] beats_q [2];
  logic [15:0] beats_d [2];

  always_comb begin
    side_beat[0] = gnt_a && req_a;
    side_beat[1] = gnt_b && req_b;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_stats
      always_comb begin
        beats_d[gi] = beats_q[gi];
        if (side_beat[gi] && (beats_q[gi] != 16'hFFFF)) begin
          beats_d[gi] = beats_q[gi] + 16'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          beats_q[gi] <= 16'd0;
        end else begin
          beats_q[gi] <= beats_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    beats_a = beats_q[0];
    beats_b = beats_q[1];
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mux2_rr_arbiter.
//
// The reference model tracks the current owner, the beats served in the
// current ownership and the round-robin pointer. It advances once per clock
// edge. A compare process checks every DUT output against the model on each
// falling edge. The directed scenarios add literal expectations, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_mux2_rr_arbiter;

  localparam int DW = 4;
  localparam int MB = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, last_a = 1'b0, last_b = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          gnt_a, gnt_b, sel, out_valid, busy;
  logic [DW-1:0] out_data;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0]   beats_a, beats_b;
`endif

  mux2_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .last_a    (last_a),
    .last_b    (last_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef MUX2_ARB_STATS_EN
    ,
    .beats_a   (beats_a),
    .beats_b   (beats_b)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: owner 0 = none, 1 = A, 2 = B
  // ---------------------------------------------------------------------------
  typedef struct {
    int owner;
    int served;
    bit ptr;     // 0: A wins a tie, 1: B wins a tie
    bit msel;
    int ba;
    int bb;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, bit ra, bit rb, bit la, bit lb);
    mstate_t n;
    bit own, oth, lst;
    n = s;
    if (s.owner == 0) begin
      if (ra && rb) n.owner = s.ptr ? 2 : 1;
      else if (ra)  n.owner = 1;
      else if (rb)  n.owner = 2;
      n.served = 0;
    end else begin
      own = (s.owner == 1) ? ra : rb;
      oth = (s.owner == 1) ? rb : ra;
      lst = (s.owner == 1) ? la : lb;
      if (own) begin
        n.served = (s.served + 1 > MB) ? MB : s.served + 1;
        if (s.owner == 1) n.ba = (s.ba < 65535) ? s.ba + 1 : 65535;
        else              n.bb = (s.bb < 65535) ? s.bb + 1 : 65535;
      end
      if (!own || lst || (n.served == MB && oth)) begin
        n.ptr    = (s.owner == 1);
        n.served = 0;
        n.owner  = oth ? ((s.owner == 1) ? 2 : 1) : 0;
      end
    end
    if (n.owner == 1) n.msel = 1'b0;
    else if (n.owner == 2) n.msel = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: 0, served: 0, ptr: 1'b0, msel: 1'b0, ba: 0, bb: 0};
    else        m <= model_next(m, req_a, req_b, last_a, last_b);
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("m_gnt_a", gnt_a, m.owner == 1);
    chk("m_gnt_b", gnt_b, m.owner == 2);
    chk("m_busy", busy, m.owner != 0);
    chk("m_sel", sel, m.msel);
    chk("m_out_valid", out_valid, (m.owner == 1 && req_a) || (m.owner == 2 && req_b));
    chk("m_out_data", out_data, m.msel ? data_b : data_a);
`ifdef MUX2_ARB_STATS_EN
    chk("m_beats_a", beats_a, m.ba);
    chk("m_beats_b", beats_b, m.bb);
`endif
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input bit ra, input bit rb, input bit la, input bit lb,
                      input logic [DW-1:0] da, input logic [DW-1:0] db);
    @(posedge clk);
    #2;
    req_a = ra; req_b = rb; last_a = la; last_b = lb; data_a = da; data_b = db;
  endtask

  task automatic look();
    #4;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset held while both sides request
    req_a = 1'b1; req_b = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_sel", sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);

    // 2: single A transfer
    do_reset();
    step(1, 0, 0, 0, 4'h1, 4'h0); look();
    chk("a_lat0_gnt_a", gnt_a, 0);
    step(1, 0, 0, 0, 4'h1, 4'h0); look();
    chk("a_gnt_a", gnt_a, 1);
    chk("a_sel", sel, 0);
    chk("a_out_data", out_data, 4'h1);
    chk("a_out_valid", out_valid, 1);
    step(0, 0, 0, 0, 4'h1, 4'h0); look();
    chk("a_drop_valid", out_valid, 0);
    step(0, 0, 0, 0, 4'h1, 4'h0); look();
    chk("a_idle_gnt_a", gnt_a, 0);
    chk("a_idle_busy", busy, 0);

    // 3: contention from IDLE, 4-beat bursts alternating with no bubble
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      step(1, 1, 0, 0, 4'h3, 4'hC); look();
      chk($sformatf("rr_n%0d_gnt_a", n), gnt_a, (n >= 2 && n <= 5) || n == 10);
      chk($sformatf("rr_n%0d_gnt_b", n), gnt_b, (n >= 6 && n <= 9));
      if (n == 6) begin
        chk("rr_n6_sel", sel, 1);
        chk("rr_n6_out_data", out_data, 4'hC);
      end
    end

`ifdef MUX2_ARB_STATS_EN
    // Stats: 16 contended beats split evenly
    do_reset();
    for (int n = 1; n <= 18; n++) step(1, 1, 0, 0, 4'h3, 4'hC);
    look();
    chk("stats_beats_a", beats_a, 8);
    chk("stats_beats_b", beats_b, 8);
`endif

    // 4: last_b on B's second beat while A waits
    do_reset();
    step(0, 1, 0, 0, 4'h0, 4'h5); look();
    step(1, 1, 0, 0, 4'h0, 4'h5); look();
    chk("lb_beat1_gnt_b", gnt_b, 1);
    step(1, 1, 0, 1, 4'h0, 4'h5); look();
    chk("lb_beat2_gnt_b", gnt_b, 1);
    chk("lb_beat2_valid", out_valid, 1);
    step(1, 1, 0, 0, 4'h0, 4'h5); look();
    chk("lb_handover_gnt_a", gnt_a, 1);
    chk("lb_handover_sel", sel, 0);

    // 5: lone B owner streams past the burst limit, then hands over
    do_reset();
    for (int n = 1; n <= 11; n++) begin
      step(0, 1, 0, 0, 4'h0, 4'h9); look();
      if (n >= 2) chk($sformatf("lone_n%0d_valid", n), out_valid, 1);
    end
    step(1, 1, 0, 0, 4'h0, 4'h9); look();
    chk("lone_extra_gnt_b", gnt_b, 1);
    chk("lone_extra_valid", out_valid, 1);
    step(1, 1, 0, 0, 4'h0, 4'h9); look();
    chk("lone_handover_gnt_a", gnt_a, 1);

    // 6: asynchronous reset in the middle of a B burst
    do_reset();
    step(0, 1, 0, 0, 4'h0, 4'h7);
    step(0, 1, 0, 0, 4'h0, 4'h7);
    step(0, 1, 0, 0, 4'h0, 4'h7);
    #1;
    chk("ar_pre_gnt_b", gnt_b, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_b", gnt_b, 0);
    chk("ar_busy", busy, 0);
    chk("ar_sel", sel, 0);
    chk("ar_out_valid", out_valid, 0);
    req_a = 1'b1; req_b = 1'b1;
    #3;
    rst_n = 1'b1;
    step(1, 1, 0, 0, 4'h0, 4'h7); look();
    chk("ar_after_gnt_a", gnt_a, 1);

    // Randomized phase with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
